// File: rtl/slow_memory_model.sv
// Fixed-latency 128-bit line memory with a level request / one-cycle ready handshake.
// The line array is never reset, so contents preloaded into mem survive rst.
module slow_memory_model #(
  parameter int MEM_NUM = 256,
  parameter int LATENCY = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:4]   mem_addr,
  input  logic [127:0]  mem_wdata,
  output logic [127:0]  mem_rdata,
  output logic          mem_ready
);

  localparam int IDX_W = $clog2(MEM_NUM);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_write_q, op_write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [127:0]       wdata_q, wdata_d;
  logic [127:0]       rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               mem_we;

  logic [127:0] mem [0:MEM_NUM-1];

  // Address bits above the line index are dropped, so addresses alias modulo MEM_NUM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:IDX_W+4];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          op_write_d = mem_write;
          idx_d      = mem_addr[IDX_W+3:4];
          wdata_d    = mem_wdata;
          cnt_d      = CNT_W'(LATENCY - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          mem_we  = op_write_q;
          if (!op_write_q) begin
            rdata_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
    end
  end

  // mem_we is only raised from BUSY, so a reset mid-transaction can never commit a write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;

endmodule

// File: tb/tb_slow_memory_model.sv
// Scoreboard bench for slow_memory_model: each accepted request queues its expected
// read data and ready cycle; a negedge monitor pops and compares on every mem_ready.
module tb_slow_memory_model;

  localparam int MEM_NUM = 256;
  localparam int LATENCY = 8;

  typedef struct {
    logic [127:0] data;
    int           cyc;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:4]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit prev_ready = 1'b0;
  exp_t sb[$];

  localparam logic [127:0] P3  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] P5  = 128'h55555555_00000005_CAFEF00D_12345678;
  localparam logic [127:0] P2  = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] P9  = 128'h99999999_DEADBEEF_99999999_DEADBEEF;
  localparam logic [127:0] P11 = 128'h11111111_BBBBBBBB_11111111_BBBBBBBB;
  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] D2  = 128'h0000FFFF_0000FFFF_12121212_34343434;
  localparam logic [127:0] X10 = 128'h10101010_10101010_10101010_10101010;
  localparam logic [127:0] Y11 = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;
  localparam logic [127:0] W9  = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;

  slow_memory_model #(.MEM_NUM(MEM_NUM), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_ready) begin
      exp_t e;
      checks++;
      if (prev_ready) begin
        errors++;
        $display("FAIL ready_double: mem_ready high two cycles in a row at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ready_unexpected: mem_ready at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (mem_rdata !== e.data) begin
          errors++;
          $display("FAIL %s_rdata: got %h expected %h", e.name, mem_rdata, e.data);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL %s_latency: ready at cycle %0d expected %0d", e.name, cyc, e.cyc);
        end
      end
    end
    prev_ready = mem_ready;
  end

  task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one transaction, hold it until the ready cycle, then drop it.
  // perturb changes addr/wdata two cycles into BUSY to show they are ignored.
  task automatic txn(input string name, input bit rd, input bit wr, input logic [27:0] addr,
                     input logic [127:0] wdata, input logic [127:0] exp_rdata,
                     input bit perturb);
    int n;
    exp_t e;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    @(posedge clk);
    #1;
    e.data = exp_rdata;
    e.cyc  = cyc + LATENCY;
    e.name = name;
    sb.push_back(e);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (perturb && n == 2) begin
        mem_addr  = addr + 28'd1;
        mem_wdata = Y11;
      end
      if (mem_ready) break;
      if (n > LATENCY + 4) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: no mem_ready within %0d cycles", name, n);
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int n, seen, e0;
    exp_t e;
    dut.mem[2]  = P2;
    dut.mem[3]  = P3;
    dut.mem[5]  = P5;
    dut.mem[9]  = P9;
    dut.mem[11] = P11;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", mem_ready);
    end
    check128("reset_rdata", mem_rdata, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    txn("rd3", 1, 0, 28'd3, '0, P3, 0);
    txn("wr7", 0, 1, 28'd7, A5, P3, 0);
    check128("mem7_after_write", dut.mem[7], A5);
    txn("rd7", 1, 0, 28'd7, '0, A5, 0);
    txn("both2", 1, 1, 28'd2, D2, A5, 0);
    check128("mem2_write_priority", dut.mem[2], D2);
    txn("wr10_perturb", 0, 1, 28'd10, X10, A5, 1);
    check128("mem10_latched", dut.mem[10], X10);
    check128("mem11_untouched", dut.mem[11], P11);

    // Reset midway through a write: nothing committed, no ready, rdata cleared.
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'd9;
    mem_wdata = W9;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (LATENCY + 3) @(negedge clk);
    check128("mem9_after_reset", dut.mem[9], P9);
    check128("rdata_after_reset", mem_rdata, '0);

    // Continuous read of an aliased address: ready every LATENCY+1 cycles.
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 28'd261;
    @(posedge clk);
    #1;
    e0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.data = P5;
      e.cyc  = e0 + LATENCY + k * (LATENCY + 1);
      e.name = "alias_rd";
      sb.push_back(e);
    end
    seen = 0;
    n = 0;
    while (seen < 3 && n < 4 * (LATENCY + 2)) begin
      @(negedge clk);
      n++;
      if (mem_ready) seen++;
    end
    mem_read = 1'b0;
    if (seen < 3) begin
      checks++;
      errors++;
      $display("FAIL alias_timeout: saw %0d ready pulses expected 3", seen);
    end

    repeat (LATENCY + 4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
